// File: rtl/pll_reset_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
//   pll_seq_state_t : sequencer FSM state encoding
//   CE_68K_DIV / CE_Z80_DIV : clock-enable divide ratios in RUN
//   sat_inc_relock  : saturating increment for the lock-loss counter
package pll_reset_seq_pkg;

   localparam int unsigned CNT_W      = 16;
   localparam int unsigned RELOCK_W   = 8;
   localparam int unsigned CE_68K_DIV = 7;
   localparam int unsigned CE_Z80_DIV = 15;
   localparam int unsigned DIV68_W    = $clog2(CE_68K_DIV);
   localparam int unsigned DIVZ80_W   = $clog2(CE_Z80_DIV);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } pll_seq_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [RELOCK_W-1:0] sat_inc_relock(input logic [RELOCK_W-1:0] v);
      return (&v) ? v : v + RELOCK_W'(1);
   endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the PLL/host side and the reset sequencer.
//   master : drives pll_locked and user_reset, observes sequencer outputs
//   slave  : the sequencer itself
interface pll_reset_seq_if;
   import pll_reset_seq_pkg::*;

   logic                pll_locked;
   logic                user_reset;
   logic                core_reset;
   logic                ready;
   logic                ce_68k;
   logic                ce_z80;
   logic [RELOCK_W-1:0] relock_count;

   modport master (
      output pll_locked,
      output user_reset,
      input  core_reset,
      input  ready,
      input  ce_68k,
      input  ce_z80,
      input  relock_count
   );

   modport slave (
      input  pll_locked,
      input  user_reset,
      output core_reset,
      output ready,
      output ce_68k,
      output ce_z80,
      output relock_count
   );

endinterface

// File: rtl/pll_reset_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; second flop gives it a cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL-lock driven core reset sequencer with CPU clock-enable generation.
//   clk_sys            : PLL output clock, single domain
//   rst_n              : asynchronous active-low reset
//   bus.pll_locked     : PLL lock, asynchronous to clk_sys
//   bus.user_reset     : synchronous level reset request
//   bus.core_reset     : registered active-high core reset (low only in RUN)
//   bus.ready          : registered, high only in RUN
//   bus.ce_68k         : one-cycle enable every CE_68K_DIV cycles in RUN
//   bus.ce_z80         : one-cycle enable every CE_Z80_DIV cycles in RUN
//   bus.relock_count   : lock losses seen in RUN, saturating
module pll_reset_seq
   import pll_reset_seq_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter int unsigned HOLD_CYCLES = 64
) (
   input  logic           clk_sys,
   input  logic           rst_n,
   pll_reset_seq_if.slave bus
);

   localparam logic [CNT_W-1:0]    LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0]    HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [DIV68_W-1:0]  DIV68_LAST = DIV68_W'(CE_68K_DIV - 1);
   localparam logic [DIVZ80_W-1:0] DIVZ_LAST  = DIVZ80_W'(CE_Z80_DIV - 1);

   logic                lock_s;
   pll_seq_state_t      state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [DIV68_W-1:0]  div68, div68_nxt;
   logic [DIVZ80_W-1:0] divz80, divz80_nxt;
   logic [RELOCK_W-1:0] relock_count, relock_nxt;
   logic                run_nxt;
   logic                stay_run;
   logic                ce68_nxt;
   logic                cez80_nxt;
   logic                core_reset;
   logic                ready;
   logic                ce_68k;
   logic                ce_z80;

   // Lock is only ever consumed through the synchronizer.
   sync_2ff u_lock_sync (
      .clk   (clk_sys),
      .rst_n (rst_n),
      .d     (bus.pll_locked),
      .q     (lock_s)
   );

   // State, shared counter, divider and output registers.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state        <= WAIT_LOCK;
         cnt          <= '0;
         div68        <= '0;
         divz80       <= '0;
         relock_count <= '0;
         core_reset   <= 1'b1;
         ready        <= 1'b0;
         ce_68k       <= 1'b0;
         ce_z80       <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         div68        <= div68_nxt;
         divz80       <= divz80_nxt;
         relock_count <= relock_nxt;
         core_reset   <= !run_nxt;
         ready        <= run_nxt;
         ce_68k       <= ce68_nxt;
         ce_z80       <= cez80_nxt;
      end
   end

   // Next-state logic; lock loss always takes priority over user_reset.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      relock_nxt = relock_count;

      unique case (state)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = STABLE;
               cnt_nxt   = '0;
            end
         end

         STABLE: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == LOCK_LAST) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         HOLD: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (bus.user_reset) begin
               cnt_nxt = '0;
            end else if (cnt == HOLD_LAST) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         RUN: begin
            if (!lock_s) begin
               state_nxt  = WAIT_LOCK;
               cnt_nxt    = '0;
               relock_nxt = sat_inc_relock(relock_count);
            end else if (bus.user_reset) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end
         end

         default: begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
         end
      endcase

      // Dividers run only while RUN persists, so the first RUN cycle sees 0.
      run_nxt  = (state_nxt == RUN);
      stay_run = (state == RUN) && run_nxt;

      div68_nxt  = '0;
      divz80_nxt = '0;
      if (stay_run) begin
         div68_nxt  = (div68 == DIV68_LAST) ? '0 : div68 + DIV68_W'(1);
         divz80_nxt = (divz80 == DIVZ_LAST) ? '0 : divz80 + DIVZ80_W'(1);
      end

      ce68_nxt  = run_nxt && (div68_nxt == DIV68_LAST);
      cez80_nxt = run_nxt && (divz80_nxt == DIVZ_LAST);
   end

   assign bus.core_reset   = core_reset;
   assign bus.ready        = ready;
   assign bus.ce_68k       = ce_68k;
   assign bus.ce_z80       = ce_z80;
   assign bus.relock_count = relock_count;

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter LOCK_CYCLES, default 1024: consecutive synchronized-lock cycles required before the reset hold starts; legal range 2..65535.
REQ-002 Parameter HOLD_CYCLES, default 64: cycles core reset stays asserted after stable lock or after a user reset; legal range 1..65535.
REQ-003 clk_sys  in  1  53.693175 MHz PLL output clock; single clock domain.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pll_locked  in  1  PLL lock, asynchronous to clk_sys.
REQ-006 user_reset  in  1  synchronous level reset request from OSD/host.
REQ-007 core_reset  out  1  synchronous active-high reset to core logic.
REQ-008 ready  out  1  high only in state RUN.
REQ-009 ce_68k  out  1  one-cycle enable, 1 of every 7 clk_sys cycles.
REQ-010 ce_z80  out  1  one-cycle enable, 1 of every 15 clk_sys cycles.
REQ-011 relock_count  out  8  count of lock losses seen in RUN, saturating at 255.

Function
REQ-012 pll_locked SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value lock_s only (2-cycle latency).
REQ-013 FSM states: WAIT_LOCK, STABLE, HOLD, RUN.
REQ-014 WAIT_LOCK: lock_s=1 -> STABLE with counter cleared; otherwise stay.
REQ-015 STABLE: counter increments each cycle lock_s=1; lock_s=0 -> WAIT_LOCK; on the LOCK_CYCLES-th consecutive cycle -> HOLD.
REQ-016 HOLD: counter counts HOLD_CYCLES cycles, then -> RUN; lock_s=0 -> WAIT_LOCK; user_reset=1 restarts the hold count.
REQ-017 RUN: lock_s=0 -> WAIT_LOCK and relock_count increments (saturating); else user_reset=1 -> HOLD with counter cleared.
REQ-018 Simultaneous lock loss and user_reset: lock loss wins.
REQ-019 core_reset SHALL be registered: 1 in every state except RUN, deasserting in the first RUN cycle; asserting the cycle after leaving RUN.
REQ-020 ready SHALL equal (state==RUN), registered and aligned with core_reset deassertion.
REQ-021 Divide-by-7 and divide-by-15 counters SHALL be held at 0 outside RUN; ce_68k and ce_z80 are 0 outside RUN.
REQ-022 In RUN, first ce_68k at RUN cycle 7 (counter 6), then every 7 cycles; first ce_z80 at RUN cycle 15, then every 15; both may coincide.
REQ-023 Shared cycle counter SHALL be 16 bits, never wraps (bounded by parameters).

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state WAIT_LOCK, counters 0, synchronizer flops 0, core_reset=1, ready=0, ce_68k=0, ce_z80=0, relock_count=0.
REQ-025 Deassertion of rst_n SHALL take effect only at a clk_sys edge; rst_n mid-operation in any state returns fully to reset values.
REQ-026 relock_count SHALL clear only on rst_n, never on user_reset.

Structure
REQ-027 Shared package holds the state enum (pll_seq_state_t) and divide constants CE_68K_DIV=7, CE_Z80_DIV=15.
REQ-028 Synchronizer SHALL be a separate sub-module sync_2ff (1-bit, async active-low reset, reset value 0).
REQ-029 Block is instantiated directly downstream of the PLL wrapper, fed by its locked output and 53.69 MHz output.

Verification
REQ-030 rst_n release, pll_locked=1 constantly, LOCK_CYCLES=16, HOLD_CYCLES=4 -> core_reset falls exactly 2+16+4 cycles (±1 for entry) after release; ready rises same cycle.
REQ-031 pll_locked glitches low for 1 cycle at STABLE count 10 -> returns to WAIT_LOCK, full 16-cycle count restarts, relock_count stays 0.
REQ-032 In RUN, drop pll_locked for 3 cycles -> core_reset=1 within 3 cycles, relock_count=1, ce_68k/ce_z80 stop; re-lock repeats full sequence.
REQ-033 In RUN, user_reset pulse 1 cycle -> core_reset high for exactly 4 cycles, relock_count unchanged; user_reset held during HOLD extends reset.
REQ-034 RUN for 105 cycles -> exactly 15 ce_68k and 7 ce_z80 pulses, coinciding at cycle 105; force 300 lock losses -> relock_count saturates at 255.
